// File: rtl/simple_alu_pkg.sv
// rtl/simple_alu_pkg.sv - shared op codes, flag indices and FSM states for simple_alu_seq
package simple_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_CMP = 4'd5,
        OP_MOV = 4'd6,
        OP_SLL = 4'd8,
        OP_SLR = 4'd9,
        OP_SRL = 4'd10,
        OP_SRA = 4'd11
    } op_e;

    localparam int FLG_S = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Codes 7 and 12..15 have no operation behind them.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == 4'd7) || (op >= 4'd12);
    endfunction

    // Codes 8..11 are the iterative shift/rotate group.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/simple_alu_core.sv
// rtl/simple_alu_core.sv - combinational add/sub/logic/mov with S/Z/C/V generation
module simple_alu_core
    import simple_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    // One extra bit holds carry-out on add and borrow on subtract.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    logic carry;
    logic ovf;
    logic legal;

    // Select the result and raw C/V per op; shift codes pass a through as the zero-amount shift.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        legal  = 1'b1;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_MOV: result = b;
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: result = a;
            default: legal = 1'b0;
        endcase
    end

    // Illegal codes report all-zero flags alongside the zero result.
    always_comb begin
        flags = '0;
        if (legal) begin
            flags[FLG_S] = result[WIDTH-1];
            flags[FLG_Z] = (result == '0);
            flags[FLG_C] = carry;
            flags[FLG_V] = ovf;
        end
    end

endmodule

// File: rtl/simple_alu_seq.sv
// rtl/simple_alu_seq.sv - handshaked ALU with iterative one-bit-per-cycle shifter
module simple_alu_seq
    import simple_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [3:0]       sop_q, sop_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;

    simple_alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (core_result),
        .flags  (core_flags)
    );

    // in_ready depends only on state and out_ready so there is no in_valid->in_ready path.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;
    assign err       = err_q;

    logic accept;
    assign accept = in_valid && in_ready;

    logic [WIDTH-1:0] step_val;
    logic             step_out;

    // One-bit step of the latched shift op; step_out is the bit leaving (or wrapping) this cycle.
    always_comb begin
        step_val = work_q;
        step_out = 1'b0;
        case (sop_q)
            OP_SLL: begin
                step_val = {work_q[WIDTH-2:0], 1'b0};
                step_out = work_q[WIDTH-1];
            end
            OP_SLR: begin
                step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                step_out = work_q[WIDTH-1];
            end
            OP_SRL: begin
                step_val = {1'b0, work_q[WIDTH-1:1]};
                step_out = work_q[0];
            end
            OP_SRA: begin
                step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                step_out = work_q[0];
            end
            default: ;
        endcase
    end

    // Next-state and datapath: IDLE and DONE share the acceptance path; SHIFT iterates until cnt hits 1.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        sop_d    = sop_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && out_ready && !in_valid) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    if (is_shift_op(op) && (shamt != '0)) begin
                        state_d = ST_SHIFT;
                        work_d  = a;
                        cnt_d   = shamt;
                        c_d     = 1'b0;
                        sop_d   = op;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = core_result;
                        flags_d  = core_flags;
                        err_d    = is_illegal_op(op);
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    state_d        = ST_DONE;
                    work_d         = step_val;
                    cnt_d          = '0;
                    c_d            = step_out;
                    result_d       = step_val;
                    flags_d        = '0;
                    flags_d[FLG_S] = step_val[WIDTH-1];
                    flags_d[FLG_Z] = (step_val == '0);
                    flags_d[FLG_C] = step_out;
                    err_d          = 1'b0;
                end else begin
                    work_d = step_val;
                    c_d    = step_out;
                    cnt_d  = cnt_q - SHW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            sop_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            sop_q    <= sop_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

endmodule
